audio_framer: RTL

- Sits directly downstream of the I2S microphone receiver.
- Consumes its 16-bit `sample` / `sample_valid` stream (one strobe per audio frame, left channel).
- Assembles samples into overlapping analysis frames of FRAME_LEN samples, advancing HOP samples per frame, in a circular buffer.
- Streams each frame to the feature-extraction stage over a valid/ready interface with frame-boundary flags.

---
 rtl/audio_framer.sv | 116 +++++++++++
 1 files changed

// File: rtl/audio_framer.sv
// Collects the mono PCM stream into overlapping frames of FRAME_LEN samples that advance by HOP samples.
// Each frame is streamed out over valid/ready, read from a circular buffer through one registered read.
module audio_framer #(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int ADDR_W    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_first,
  output logic        m_last,
  output logic [15:0] frame_count,
  output logic        overrun
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = $clog2(FRAME_LEN + 1);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   FRAME_C  = (ADDR_W + 1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]   HOP_C    = (ADDR_W + 1)'(HOP);
  localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] HOP_A    = ADDR_W'(HOP);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  END_IDX  = IDX_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wp_reg;
  logic [ADDR_W-1:0] rs_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   occ_reg;
  logic [ADDR_W:0]   occ_next;
  logic [IDX_W-1:0]  rd_idx_reg;
  state_t            state_reg;
  logic              wr_en;
  logic              xfer;
  logic              load;

  // A full buffer means the oldest unread frame would be clobbered, so the sample is dropped.
  assign wr_en   = sample_valid && (occ_reg != DEPTH_C);
  assign rd_addr = rs_reg + ADDR_W'(rd_idx_reg);
  assign xfer    = m_valid && m_ready;
  // Fetch the next word whenever the output register is empty or being drained this cycle.
  assign load    = (state_reg == S_STREAM) && (rd_idx_reg != END_IDX) && (!m_valid || m_ready);

  always_comb begin
    occ_next = occ_reg;
    if (state_reg == S_DONE) occ_next = occ_next - HOP_C;
    if (wr_en)               occ_next = occ_next + OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_reg] <= sample;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_reg      <= '0;
      rs_reg      <= '0;
      occ_reg     <= '0;
      rd_idx_reg  <= '0;
      state_reg   <= S_WAIT;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      occ_reg <= occ_next;
      if (wr_en) wp_reg <= wp_reg + ADDR_ONE;
      if (sample_valid && !wr_en) overrun <= 1'b1;

      case (state_reg)
        S_WAIT: begin
          if (occ_reg >= FRAME_C) begin
            state_reg  <= S_STREAM;
            rd_idx_reg <= '0;
          end
        end
        S_STREAM: begin
          if (load) begin
            m_data     <= mem[rd_addr];
            m_valid    <= 1'b1;
            m_first    <= (rd_idx_reg == '0);
            m_last     <= (rd_idx_reg == LAST_IDX);
            rd_idx_reg <= rd_idx_reg + IDX_ONE;
          end else if (xfer) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
          end
          if (xfer && m_last) state_reg <= S_DONE;
        end
        S_DONE: begin
          rs_reg      <= rs_reg + HOP_A;
          frame_count <= frame_count + 16'd1;
          state_reg   <= S_WAIT;
        end
        default: state_reg <= S_WAIT;
      endcase
    end
  end
endmodule
